image_streamer: RTL and testbench
=================================

# image_streamer

Raster-order source that feeds the convolutional layer's input side: on `start` it reads one image from an external synchronous RAM, one pixel word (all input channels) per cycle, and presents it on `pixel_data` qualified by `pixel_en`, which drives the layer's `clk_en` directly. It owns frame sequencing, downstream stalls via `hold`, and frame-boundary flags, so the convolutional layer stays a pure stream consumer.

## Interface
- `D_WIDTH`, 8: bits per channel sample.
- `D_CHANNELS`, 1: channels per pixel word; RAM word width is `D_WIDTH*D_CHANNELS`.
- `IMAGE_SIZE`, 28: image side length in pixels, square image; must be ≥ 2.
- `PAD`, 1: zero-border width; used only when `IMAGE_STREAMER_PAD_EN` is defined; must be ≥ 1.

- `clk`  in  1  clock; one clock domain, synchronous, active-high reset.
- `rst`  in  1  synchronous reset.
- `start`  in  1  begin one frame; sampled only in IDLE.
- `hold`  in  1  downstream stall; freezes the pipeline.
- `mem_addr`  out  `LOG2(IMAGE_SIZE*IMAGE_SIZE)`  RAM read address, row-major.
- `mem_rd_en`  out  1  RAM read strobe.
- `mem_data`  in  `D_WIDTH*D_CHANNELS`  RAM read data, valid 1 cycle after `mem_rd_en`; held stable while `mem_rd_en`=0.
- `pixel_data`  out  `D_WIDTH*D_CHANNELS`  pixel word; channel i in slice i, LSB-first.
- `pixel_en`  out  1  `pixel_data` valid; connects to the convolutional layer's `clk_en`.
- `frame_start`  out  1  high with the first pixel of a frame.
- `frame_last`  out  1  high with the final pixel of a frame.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse after the final pixel.

## Operation
- States: IDLE, STREAM, DRAIN.
- IDLE: `start`=1 → STREAM; row/col counters and `mem_addr` cleared; `busy` set.
- STREAM: one position issued per cycle with `hold`=0; col increments, wraps to 0 at side−1 and increments row. After the last position issues → DRAIN.
- DRAIN: waits for the two pipeline stages to empty. When the final pixel is presented → IDLE, and `done` pulses the next cycle.
- Pipeline: issue stage → s1, where RAM data is valid → output register. Stages advance only on cycles with `hold`=0.
- `mem_rd_en` = issue pending & ~`hold` & interior position; combinational.
- `pixel_en` = output-valid & ~`hold`. Each pixel is presented on exactly one `hold`=0 cycle; `pixel_data` is stable during `hold`.
- `mem_addr` increments only after an interior read; it never wraps within a frame.
- `start` is ignored while `busy`=1.
- `hold` in IDLE has no effect.
- Reset at any time: next cycle IDLE, all counters 0, pipeline valids cleared, no `done` pulse.
- Reset values: `mem_addr`=0, `mem_rd_en`=0, `pixel_data`=0, `pixel_en`=0, `frame_start`=0, `frame_last`=0, `busy`=0, `done`=0.

## Timing
- `start` accepted at cycle 0 → first read at cycle 1 → first `pixel_en` at cycle 3, with `hold`=0 throughout.
- Throughput: 1 pixel per cycle. Each `hold` cycle adds exactly one cycle.
- Frame of N positions, no hold: last `pixel_en` at cycle N+2, `done` at N+3. `busy` falls at N+3, and `start` is accepted in that same cycle.
- N = IMAGE_SIZE² without padding, (IMAGE_SIZE+2·PAD)² with padding.

## Configuration
- `IMAGE_STREAMER_PAD_EN` defined:
  - Counters span IMAGE_SIZE+2·PAD per side.
  - Border positions issue no RAM read and emit `pixel_data`=0 with `pixel_en` still asserted.
  - `frame_start` and `frame_last` mark the padded corners.
- `IMAGE_STREAMER_PAD_EN` undefined:
  - `PAD` is ignored; every position is a RAM read.
  - Pad flag logic is removed.

## Structure
- Shared definitions header: `LOG2`, `L`/`R` slice macros, state encodings IDLE=0, STREAM=1, DRAIN=2.
- Sub-module `raster_counter`:
  - Parameter SIDE.
  - Row/col counters with `advance` input.
  - Outputs `last_col`, `last_pos`, and `border` (interior-position test).
- Top level holds the FSM, the two-stage pipeline with valid/pad/last flags, and the output registers.

## Test plan
- IMAGE_SIZE=4, D_CHANNELS=2, RAM[a]={a+100,a}, no pad; `start` at cycle 0 → `pixel_en` cycles 3–18, data {100,0}…{115,15}; `frame_start` at 3, `frame_last` at 18, `done` at 19.
- Same setup, `hold` high cycles 5–7 → pixels 0–1 at cycles 3–4, pixel 2 at 8, no pixel repeated or skipped; `done` at 22.
- `start` pulsed at cycle 10 mid-frame → ignored, single frame only. Second `start` in `done` cycle → next first pixel 3 cycles later.
- `rst` at cycle 9 mid-frame → cycle 10: all outputs 0, IDLE, no `done`. Later `start` → frame restarts from address 0.
- PAD_EN, IMAGE_SIZE=4, PAD=1 → 36 pixels; row 0, row 5, col 0 and col 5 are zero; interior equals RAM 0–15 in order; `mem_rd_en` asserted exactly 16 times.
- `hold` held high from cycle 0 with `start` → `busy`=1, `mem_rd_en`=0, no `pixel_en`; on release, normal sequence resumes at release+1.

Source files
------------

// File: rtl/image_streamer_pkg.sv
//------------------------------------------------------------------------------
// Module   : image_streamer_pkg
// Purpose  : Definitions shared by image_streamer and raster_counter.
//            LOG2 width macro, L/R channel-slice bound macros and the
//            streamer FSM state encoding.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef IMAGE_STREAMER_DEFS
`define IMAGE_STREAMER_DEFS
// Address/counter width for a value range of x entries.
`define LOG2(x) $clog2(x)
// Channel i of a packed word with w-bit channels occupies [L(i,w):R(i,w)].
`define L(i, w) (((i) + 1) * (w) - 1)
`define R(i, w) ((i) * (w))
`endif

package image_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/image_streamer_raster_counter.sv
//------------------------------------------------------------------------------
// Module   : raster_counter
// Purpose  : Row/column position counter for a SIDE x SIDE raster scan.
//            Column advances on 'advance', wraps at SIDE-1 and steps the row.
// Ports    : clk, rst      clock, synchronous active-high reset
//            clear         force position back to (0,0)
//            advance       step to the next raster position
//            last_col      current column is SIDE-1
//            last_pos      current position is the final one of the frame
//            border        current position lies in the PAD-wide zero border
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module raster_counter
  import image_streamer_pkg::*;
#(
  parameter int SIDE = 28,
  parameter int PAD  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  output logic last_col,
  output logic last_pos,
  output logic border
);

  localparam int CW = `LOG2(SIDE);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          last_row;

  assign last_col = (col_q == CW'(SIDE - 1));
  assign last_row = (row_q == CW'(SIDE - 1));
  assign last_pos = last_col & last_row;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  generate
    if (PAD > 0) begin : g_border
      assign border = (row_q < CW'(PAD)) || (row_q >= CW'(SIDE - PAD)) ||
                      (col_q < CW'(PAD)) || (col_q >= CW'(SIDE - PAD));
    end else begin : g_no_border
      assign border = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/image_streamer.sv
//------------------------------------------------------------------------------
// Module   : image_streamer
// Purpose  : Reads one square image from a synchronous RAM in raster order and
//            streams it one pixel word per cycle, with downstream stall (hold),
//            frame start/last flags and a done pulse.
// Ports    : clk, rst          clock, synchronous active-high reset
//            start             begin a frame (sampled only in IDLE)
//            hold              downstream stall, freezes the pipeline
//            mem_addr/rd_en    RAM read address (row-major) and strobe
//            mem_data          RAM read data, valid one cycle after rd_en
//            pixel_data/en     pixel word and its qualifier
//            frame_start/last  first / final pixel of the frame
//            busy, done        frame in progress, one-cycle completion pulse
// Options  : IMAGE_STREAMER_PAD_EN  adds a PAD-wide zero border around the
//            image; border positions emit zero pixels without RAM reads.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module image_streamer
  import image_streamer_pkg::*;
#(
  parameter int D_WIDTH    = 8,
  parameter int D_CHANNELS = 1,
  parameter int IMAGE_SIZE = 28,
  parameter int PAD        = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      hold,
  output logic [`LOG2(IMAGE_SIZE*IMAGE_SIZE)-1:0]   mem_addr,
  output logic                                      mem_rd_en,
  input  logic [D_WIDTH*D_CHANNELS-1:0]             mem_data,
  output logic [D_WIDTH*D_CHANNELS-1:0]             pixel_data,
  output logic                                      pixel_en,
  output logic                                      frame_start,
  output logic                                      frame_last,
  output logic                                      busy,
  output logic                                      done
);

  localparam int AW = `LOG2(IMAGE_SIZE * IMAGE_SIZE);
  localparam int DW = D_WIDTH * D_CHANNELS;
  localparam logic [AW-1:0] c_addr_max = AW'(IMAGE_SIZE * IMAGE_SIZE - 1);

`ifdef IMAGE_STREAMER_PAD_EN
  localparam int c_side = IMAGE_SIZE + 2 * PAD;
  localparam int c_pad  = PAD;
`else
  localparam int c_side       = IMAGE_SIZE;
  localparam int c_pad        = 0;
  localparam int c_unused_pad = PAD;
`endif

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            first_q, first_d;      // next issued position is frame's first
  logic            s1_valid_q, s1_valid_d;
  logic            s1_first_q, s1_first_d;
  logic            s1_last_q, s1_last_d;
  logic            out_valid_q, out_valid_d;
  logic            out_first_q, out_first_d;
  logic            out_last_q, out_last_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            done_q, done_d;

  logic            w_issue;
  logic            w_last_pos;
  logic            w_border;
  logic            w_unused_last_col;

  raster_counter #(
    .SIDE (c_side),
    .PAD  (c_pad)
  ) u_raster_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state_q == IDLE) & start),
    .advance  (w_issue),
    .last_col (w_unused_last_col),
    .last_pos (w_last_pos),
    .border   (w_border)
  );

  // A position issues on every un-stalled STREAM cycle, read or border.
  assign w_issue     = (state_q == STREAM) & ~hold;
  assign mem_rd_en   = w_issue & ~w_border;
  assign mem_addr    = addr_q;
  assign pixel_en    = out_valid_q & ~hold;
  assign pixel_data  = out_data_q;
  assign frame_start = pixel_en & out_first_q;
  assign frame_last  = pixel_en & out_last_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

`ifdef IMAGE_STREAMER_PAD_EN
  logic s1_pad_q, s1_pad_d;

  always_comb begin
    s1_pad_d = s1_pad_q;
    if (!hold) s1_pad_d = w_border;
  end

  always_ff @(posedge clk) begin
    if (rst) s1_pad_q <= 1'b0;
    else     s1_pad_q <= s1_pad_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    first_d     = first_q;
    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          addr_d  = '0;
          first_d = 1'b1;
        end
      end
      STREAM: begin
        if (w_issue && w_last_pos) state_d = DRAIN;
      end
      DRAIN: begin
        if (pixel_en && out_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_issue) first_d = 1'b0;

    // Saturate rather than wrap so the address never aliases within a frame.
    if (mem_rd_en && (addr_q != c_addr_max)) addr_d = addr_q + 1'b1;

    if (!hold) begin
      s1_valid_d  = w_issue;
      s1_first_d  = first_q;
      s1_last_d   = w_last_pos;
      out_valid_d = s1_valid_q;
      out_first_d = s1_first_q;
      out_last_d  = s1_last_q;
      if (s1_valid_q) begin
`ifdef IMAGE_STREAMER_PAD_EN
        out_data_d = s1_pad_q ? '0 : mem_data;
`else
        out_data_d = mem_data;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      first_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      first_q     <= first_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_image_streamer.sv
//------------------------------------------------------------------------------
// Module   : tb_image_streamer
// Purpose  : Directed self-checking bench for image_streamer with
//            IMAGE_SIZE=4, D_CHANNELS=2, RAM[a] = {a+100, a}.
//            Build with IMAGE_STREAMER_PAD_EN to exercise the padded frame.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_image_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic [3:0]  mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_data = '0;
  logic [15:0] pixel_data;
  logic        pixel_en;
  logic        frame_start;
  logic        frame_last;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-run event logs: cycle numbers relative to the start cycle (0).
  int pe_cyc[$];
  int pe_data[$];
  int fs_cyc[$];
  int fl_cyc[$];
  int done_cyc[$];
  int rd_cnt;
  int rd_first;
  logic [25:0] snap_all;

  always #5 clk = ~clk;

  image_streamer #(
    .D_WIDTH    (8),
    .D_CHANNELS (2),
    .IMAGE_SIZE (4),
    .PAD        (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .hold        (hold),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_data    (mem_data),
    .pixel_data  (pixel_data),
    .pixel_en    (pixel_en),
    .frame_start (frame_start),
    .frame_last  (frame_last),
    .busy        (busy),
    .done        (done)
  );

  // Synchronous RAM model: word a holds {a+100, a}.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= {8'd100 + {4'd0, mem_addr}, 4'd0, mem_addr};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int pix(input int k);
    return ((k + 100) << 8) | k;
  endfunction

  // Runs ncyc cycles; start at cycle 0 (and st2/st3), hold over [hold_lo,hold_hi],
  // rst during rst_c. Outputs sampled mid-cycle; snapshot taken at snap_c.
  task automatic run(input int ncyc, input int hold_lo, input int hold_hi,
                     input int st2, input int st3, input int rst_c, input int snap_c);
    pe_cyc.delete(); pe_data.delete(); fs_cyc.delete(); fl_cyc.delete(); done_cyc.delete();
    rd_cnt = 0; rd_first = -1; snap_all = '1;
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == st2) || (c == st3);
      hold  = (c >= hold_lo) && (c <= hold_hi);
      rst   = (c == rst_c);
      #1;
      if (pixel_en) begin pe_cyc.push_back(c); pe_data.push_back(int'(pixel_data)); end
      if (frame_start) fs_cyc.push_back(c);
      if (frame_last)  fl_cyc.push_back(c);
      if (done)        done_cyc.push_back(c);
      if (mem_rd_en) begin
        if (rd_first < 0) rd_first = c;
        rd_cnt++;
      end
      if (c == snap_c)
        snap_all = {mem_addr, mem_rd_en, pixel_data, pixel_en, frame_start, frame_last, busy, done};
      @(posedge clk); #1;
    end
    start = 1'b0; hold = 1'b0; rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mem_addr",    32'(mem_addr),    32'd0);
    check("rst_mem_rd_en",   32'(mem_rd_en),   32'd0);
    check("rst_pixel_data",  32'(pixel_data),  32'd0);
    check("rst_pixel_en",    32'(pixel_en),    32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_frame_last",  32'(frame_last),  32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_done",        32'(done),        32'd0);
    @(posedge clk); #1;

`ifdef IMAGE_STREAMER_PAD_EN
    // Padded 6x6 frame: border zeros, interior = RAM 0..15 in order.
    run(45, -1, -1, -1, -1, -1, -1);
    check("pad_pixel_count", 32'(pe_cyc.size()), 32'd36);
    check("pad_rd_count",    32'(rd_cnt),        32'd16);
    check("pad_first_pe",    32'(qat(pe_cyc, 0)),  32'd3);
    check("pad_last_pe",     32'(qat(pe_cyc, 35)), 32'd38);
    check("pad_frame_start", 32'(qat(fs_cyc, 0)),  32'd3);
    check("pad_frame_last",  32'(qat(fl_cyc, 0)),  32'd38);
    check("pad_done",        32'(qat(done_cyc, 0)), 32'd39);
    for (int k = 0; k < 36; k++) begin
      int r, c, e;
      r = k / 6; c = k % 6;
      e = (r == 0 || r == 5 || c == 0 || c == 5) ? 0 : pix((r - 1) * 4 + (c - 1));
      check($sformatf("pad_data[%0d]", k), 32'(qat(pe_data, k)), 32'(e));
    end
`else
    // Basic frame.
    run(25, -1, -1, -1, -1, -1, 1);
    check("basic_pixel_count", 32'(pe_cyc.size()),   32'd16);
    check("basic_first_rd",    32'(rd_first),        32'd1);
    check("basic_rd_count",    32'(rd_cnt),          32'd16);
    check("basic_busy_c1",     32'(snap_all[1]),     32'd1);
    check("basic_first_pe",    32'(qat(pe_cyc, 0)),  32'd3);
    check("basic_last_pe",     32'(qat(pe_cyc, 15)), 32'd18);
    check("basic_frame_start", 32'(qat(fs_cyc, 0)),  32'd3);
    check("basic_frame_last",  32'(qat(fl_cyc, 0)),  32'd18);
    check("basic_done",        32'(qat(done_cyc, 0)), 32'd19);
    check("basic_done_count",  32'(done_cyc.size()), 32'd1);
    for (int k = 0; k < 16; k++)
      check($sformatf("basic_data[%0d]", k), 32'(qat(pe_data, k)), 32'(pix(k)));

    // Hold over cycles 5..7: pixel 2 held stable, presented at 8.
    run(26, 5, 7, -1, -1, -1, 6);
    check("hold_pixel_count", 32'(pe_cyc.size()),   32'd16);
    check("hold_pe1",         32'(qat(pe_cyc, 1)),  32'd4);
    check("hold_pe2",         32'(qat(pe_cyc, 2)),  32'd8);
    check("hold_last_pe",     32'(qat(pe_cyc, 15)), 32'd21);
    check("hold_done",        32'(qat(done_cyc, 0)), 32'd22);
    check("hold_stable_data", 32'(snap_all[20:5]),  32'h6602);
    check("hold_no_rd",       32'(snap_all[21]),    32'd0);
    check("hold_no_pe",       32'(snap_all[4]),     32'd0);
    for (int k = 0; k < 16; k++)
      check($sformatf("hold_data[%0d]", k), 32'(qat(pe_data, k)), 32'(pix(k)));

    // start mid-frame ignored; start in done cycle begins the next frame.
    run(45, -1, -1, 10, 19, -1, -1);
    check("restart_pixel_count", 32'(pe_cyc.size()),    32'd32);
    check("restart_fs_count",    32'(fs_cyc.size()),    32'd2);
    check("restart_done0",       32'(qat(done_cyc, 0)), 32'd19);
    check("restart_pe16",        32'(qat(pe_cyc, 16)),  32'd22);
    check("restart_data16",      32'(qat(pe_data, 16)), 32'(pix(0)));
    check("restart_done1",       32'(qat(done_cyc, 1)), 32'd38);
    check("restart_done_count",  32'(done_cyc.size()),  32'd2);

    // Reset mid-frame: cycle 10 all outputs 0, no done.
    run(25, -1, -1, -1, -1, 9, 10);
    check("midrst_outputs",    32'(snap_all),        32'd0);
    check("midrst_done_count", 32'(done_cyc.size()), 32'd0);
    run(25, -1, -1, -1, -1, -1, -1);
    check("afterrst_first_pe",   32'(qat(pe_cyc, 0)),  32'd3);
    check("afterrst_first_data", 32'(qat(pe_data, 0)), 32'(pix(0)));
    check("afterrst_count",      32'(pe_cyc.size()),   32'd16);

    // hold high from the start cycle through cycle 4.
    run(28, 0, 4, -1, -1, -1, 2);
    check("hold0_busy",      32'(snap_all[1]),      32'd1);
    check("hold0_rd",        32'(snap_all[21]),     32'd0);
    check("hold0_first_rd",  32'(rd_first),         32'd5);
    check("hold0_first_pe",  32'(qat(pe_cyc, 0)),   32'd7);
    check("hold0_count",     32'(pe_cyc.size()),    32'd16);
    check("hold0_done",      32'(qat(done_cyc, 0)), 32'd23);
    check("hold0_last_data", 32'(qat(pe_data, 15)), 32'(pix(15)));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
